spike_out_fifo: RTL and testbench

Downstream stage of `neuron_core`. Captures the per-timestep spike bitmap the core produces and serialises it into `{timestep, neuron_index}` events. The events are buffered in a FIFO that firmware drains over the Wishbone slave bus. Sits beside `neuron_core` inside `user_project_wrapper`; the wrapper muxes `wbs_dat_o`/`wbs_ack_o` by address.

---
 rtl/spike_out_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/spike_out_fifo.sv | 152 +++++++++++++++
 tb/tb_spike_out_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_out_pkg.sv
// Shared constants for the spike event FIFO: register offsets, STATUS bit positions, scan states.
package spike_out_pkg;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;

  localparam int STAT_CNT_LSB   = 0;
  localparam int STAT_CNT_W     = 8;
  localparam int STAT_FLUSH_BIT = 0;
  localparam int STAT_OVF_BIT   = 8;
  localparam int STAT_BUSY_BIT  = 9;
  localparam int DATA_VLD_BIT   = 31;

  function automatic int entry_w(input int ts_w, input int idx_w);
    return ts_w + idx_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; push is gated only by full, never by the same-cycle pop.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/spike_out_fifo.sv
// Serialises per-timestep spike bitmaps into {ts, idx} events, queued for Wishbone readout.
module spike_out_fifo
  import spike_out_pkg::*;
#(
  parameter int          NUM_NEURONS = 256,
  parameter int          TS_W        = 8,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike_valid,
  input  logic [NUM_NEURONS-1:0] spike_vec,
  input  logic [TS_W-1:0]        spike_ts,
  output logic                   spike_ready,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  input  logic [3:0]             wbs_sel_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o
);
  localparam int IDX_W   = $clog2(NUM_NEURONS);
  localparam int ENTRY_W = entry_w(TS_W, IDX_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  scan_state_t            state, state_nxt;
  logic [NUM_NEURONS-1:0] vec_q, vec_nxt;
  logic [TS_W-1:0]        ts_q, ts_nxt;
  logic [IDX_W-1:0]       idx;
  logic                   push;
  logic                   overflow;
  logic                   drop;

  logic [ENTRY_W-1:0]     fifo_dout;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic                   req;
  logic [3:0]             reg_off;
  logic                   rd_pop;
  logic                   flush;
  logic                   ovf_clr;
  logic [31:0]            rdata;

  assign idx         = lowest_set(vec_q);
  assign spike_ready = (state == IDLE);
  assign drop        = spike_valid & (state == SCAN);

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_q;
    ts_nxt    = ts_q;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (spike_valid) begin
          vec_nxt   = spike_vec;
          ts_nxt    = spike_ts;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (vec_q == '0) begin
          state_nxt = IDLE;
        end else if (!fifo_full) begin
          push    = 1'b1;
          // v & (v-1) clears exactly the lowest set bit, i.e. bit idx
          vec_nxt = vec_q & (vec_q - 1'b1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      vec_q <= '0;
      ts_q  <= '0;
    end else begin
      state <= state_nxt;
      vec_q <= vec_nxt;
      ts_q  <= ts_nxt;
    end
  end

  sync_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_pop),
    .flush (flush),
    .din   ({ts_q, idx}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A request is taken only while ack is low, which yields the every-other-cycle ack rhythm.
  assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_off = {wbs_adr_i[3:2], 2'b00};
  assign rd_pop  = req & ~wbs_we_i & (reg_off == REG_DATA);
  assign flush   = req & wbs_we_i & (reg_off == REG_STATUS) & wbs_dat_i[STAT_FLUSH_BIT];
  assign ovf_clr = req & wbs_we_i & (reg_off == REG_STATUS) & wbs_dat_i[STAT_OVF_BIT];

  always_comb begin
    rdata = '0;
    case (reg_off)
      REG_DATA: begin
        if (!fifo_empty) begin
          rdata[DATA_VLD_BIT]  = 1'b1;
          rdata[ENTRY_W-1:0]   = fifo_dout;
        end
      end
      REG_STATUS: begin
        rdata[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
        rdata[STAT_OVF_BIT]               = overflow;
        rdata[STAT_BUSY_BIT]              = (state == SCAN);
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      overflow  <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:9], wbs_dat_i[7:1], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_spike_out_fifo.sv
// Directed + randomized bench for spike_out_fifo with a queue-based event model.
module tb_spike_out_fifo;
  localparam int          N    = 256;
  localparam logic [31:0] BASE = 32'h3000_1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          spike_valid = 1'b0;
  logic [N-1:0]  spike_vec = '0;
  logic [7:0]    spike_ts = '0;
  logic          spike_ready;
  logic          wbs_cyc_i = 1'b0;
  logic          wbs_stb_i = 1'b0;
  logic          wbs_we_i = 1'b0;
  logic [31:0]   wbs_adr_i = '0;
  logic [31:0]   wbs_dat_i = '0;
  logic [3:0]    wbs_sel_i = 4'hF;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  spike_out_fifo dut (
    .clk(clk), .rst(rst),
    .spike_valid(spike_valid), .spike_vec(spike_vec), .spike_ts(spike_ts), .spike_ready(spike_ready),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input int cnt, input int ovf, input int busy);
    return 32'(cnt) | (32'(ovf) << 8) | (32'(busy) << 9);
  endfunction

  // Every set bit becomes one event, lowest neuron first, tagged with the bitmap's timestep.
  function automatic void model_add(input logic [N-1:0] v, input logic [7:0] ts);
    for (int i = 0; i < N; i++)
      if (v[i]) exp_q.push_back(32'h8000_0000 | (32'(ts) << 8) | 32'(i));
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic acked);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = wd;
    rd = '0; acked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd = wbs_dat_o;
      if (wbs_ack_o) begin acked = 1'b1; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d; logic a;
    wb_xfer(1'b0, BASE + 32'(off), 32'h0, d, a);
    check({tag, "_ack"}, 32'(a), 32'd1);
    check(tag, d, exp);
  endtask

  task automatic wr_check(input string tag, input logic [3:0] off, input logic [31:0] wd);
    logic [31:0] d; logic a;
    wb_xfer(1'b1, BASE + 32'(off), wd, d, a);
    check({tag, "_ack"}, 32'(a), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    rd_check(tag, 4'h0, e);
  endtask

  // Used while a scan may still be pushing: an empty read is legal, a nonempty one must match order.
  task automatic pop_any(input string tag);
    logic [31:0] d; logic a; logic [31:0] e;
    wb_xfer(1'b0, BASE, 32'h0, d, a);
    check({tag, "_ack"}, 32'(a), 32'd1);
    if (d[31]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
      check(tag, d, e);
    end else begin
      check({tag, "_empty"}, d, 32'h0);
    end
  endtask

  task automatic send(input logic [N-1:0] v, input logic [7:0] ts);
    spike_vec = v; spike_ts = ts; spike_valid = 1'b1;
    model_add(v, ts);
    @(negedge clk);
    spike_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (spike_ready) break;
      @(negedge clk);
    end
    check({tag, "_ready"}, 32'(spike_ready), 32'd1);
  endtask

  initial begin
    logic [N-1:0] v;
    logic [31:0]  d;
    logic         a;
    int           low_cycles;
    int unsigned  dens;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(spike_ready), 32'd1);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rd_check("rst_status", 4'h4, status_word(0, 0, 0));

    // Three-bit bitmap, ts=5
    v = '0; v[3] = 1'b1; v[7] = 1'b1; v[200] = 1'b1;
    check("t2_ready_before", 32'(spike_ready), 32'd1);
    send(v, 8'h05);
    low_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      if (spike_ready) break;
      low_cycles++;
      @(negedge clk);
    end
    check("t2_busy_cycles", 32'(low_cycles), 32'd4);
    rd_check("t2_status", 4'h4, status_word(3, 0, 0));
    rd_check("t2_pop0", 4'h0, 32'h8000_0503);
    rd_check("t2_pop1", 4'h0, 32'h8000_0507);
    rd_check("t2_pop2", 4'h0, 32'h8000_05C8);
    rd_check("t2_pop_empty", 4'h0, 32'h0);
    exp_q.delete();

    // Twenty random bits: stall at full, then drain
    v = '0;
    while ($countones(v) < 20) v[$urandom_range(0, N-1)] = 1'b1;
    send(v, 8'h9A);
    repeat (30) @(negedge clk);
    rd_check("t3_stall_status", 4'h4, status_word(16, 0, 1));
    for (int i = 0; i < 4; i++) pop_check("t3_drain4");
    wait_ready("t3_done");
    rd_check("t3_status_done", 4'h4, status_word(16, 0, 0));
    for (int i = 0; i < 17; i++) pop_check("t3_drain");

    // Drop while scanning sets sticky overflow
    v = '0; v[1] = 1'b1; v[2] = 1'b1; v[9] = 1'b1;
    send(v, 8'h21);
    check("t4_busy", 32'(spike_ready), 32'd0);
    spike_vec = '1; spike_ts = 8'hEE; spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0;
    wait_ready("t4_done");
    rd_check("t4_ovf_set", 4'h4, status_word(3, 1, 0));
    wr_check("t4_ovf_clr_wr", 4'h4, 32'h100);
    rd_check("t4_ovf_clr", 4'h4, status_word(3, 0, 0));
    for (int i = 0; i < 4; i++) pop_check("t4_drain");

    // Pop coinciding with a scan push at count=4
    v = '0; v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1; v[40] = 1'b1;
    send(v, 8'h33);
    wait_ready("t5_fill");
    rd_check("t5_cnt4", 4'h4, status_word(4, 0, 0));
    v = '0; v[99] = 1'b1;
    send(v, 8'h44);
    pop_check("t5_pop_with_push");
    wait_ready("t5_done");
    rd_check("t5_cnt_kept", 4'h4, status_word(4, 0, 0));
    for (int i = 0; i < 5; i++) pop_check("t5_drain");

    // Flush, spare registers, out-of-window access
    v = '0; v[0] = 1'b1; v[50] = 1'b1; v[100] = 1'b1; v[150] = 1'b1; v[250] = 1'b1; v[255] = 1'b1;
    send(v, 8'h66);
    wait_ready("t6_fill");
    rd_check("t6_cnt6", 4'h4, status_word(6, 0, 0));
    wr_check("t6_flush_wr", 4'h4, 32'h1);
    exp_q.delete();
    rd_check("t6_flushed", 4'h4, status_word(0, 0, 0));
    pop_check("t6_pop_empty");
    rd_check("t6_reg8", 4'h8, 32'h0);
    wr_check("t6_regc_wr", 4'hC, 32'hFFFF_FFFF);
    rd_check("t6_status_after_c", 4'h4, status_word(0, 0, 0));
    wb_xfer(1'b0, BASE + 32'h40, 32'h0, d, a);
    check("t6_oow_noack", 32'(a), 32'd0);
    check("t6_oow_dat", d, 32'h0);

    // Randomized bitmaps with interleaved reads
    for (int b = 0; b < 8; b++) begin
      dens = $urandom_range(0, 40);
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < dens);
      wait_ready("rnd_pre");
      send(v, 8'($urandom));
      for (int t = 0; t < 3000; t++) begin
        if (spike_ready) break;
        if ($urandom_range(0, 2) == 0) @(negedge clk);
        else pop_any("rnd_pop");
      end
      check("rnd_done", 32'(spike_ready), 32'd1);
    end
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0) break;
      pop_any("rnd_drain");
    end
    check("rnd_model_empty", 32'(exp_q.size()), 32'd0);
    rd_check("rnd_status_end", 4'h4, status_word(0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
